dram_req_scheduler: RTL
=======================

Name: dram_req_scheduler

Overview:
Request front-end directly upstream of the DRAM command FSM, which is built on dram_state_t and cmd_t. It buffers read/write requests in a FIFO and splits each physical address into rank, bank group, bank, row and column. It tags each request as row-hit, row-conflict or row-miss using an open-row table. It also owns the tREFI refresh timer and hands refresh requests to the command FSM ahead of pending traffic.

Parameters:
FIFO_DEPTH, 8, request entries (power of 2)
REFI_CYCLES, dram_pkg::tREFI, refresh interval in CLK cycles
MAX_REF_DEBT, 8, maximum postponed refreshes (DDR4 limit)

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
init_done  in  1  command FSM has left ZQ_CL and reached IDLE
req_valid  in  1  upstream request valid
req_ready  out  1  FIFO can accept (= !full)
req_addr  in  ADDR_W(33)  physical address
req_wr  in  1  1 = write, 0 = read
req_wdata  in  64  write data (word_t)
issue_valid  out  1  output register holds a request
issue_ready  in  1  command FSM accepts request
issue_wr  out  1  write flag
issue_rank  out  1  rank
issue_bg  out  2  bank group
issue_bank  out  2  bank
issue_row  out  15  row
issue_col  out  10  column
issue_wdata  out  64  write data
issue_hit  out  1  row already open in this bank
issue_conflict  out  1  a different row is open (FSM precharges first)
ref_req  out  1  refresh request to FSM
ref_ack  in  1  one-cycle pulse: REFRESHING complete
fifo_count  out  4  occupancy, 0..FIFO_DEPTH

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low (nRST).
- Reset values: all outputs 0, FIFO empty, open-row table invalid, refresh counter = REFI_CYCLES-1, ref_debt = 0, state WAIT_INIT.
- Address split (MSB to LSB): rank[32], row[31:17], bg[16:15], bank[14:13], col[12:3], offset[2:1], ignore[0]. Offset and ignore are dropped.
- FIFO:
  - Accepts when req_valid && req_ready.
  - When full, req_ready = 0 even if a dequeue occurs in the same cycle.
  - Simultaneous enqueue and dequeue when not full leaves count unchanged.
- Output register:
  - Loads from the FIFO head when empty, or when issue_valid && issue_ready, provided state == RUN and ref_debt == 0.
  - Minimum latency: request accepted at edge N gives issue_valid = 1 after edge N+1.
  - Once asserted, issue_valid and all issue_* fields stay stable until issue_ready.
- Open-row table: 32 entries indexed {rank, bg, bank}, each holding valid + 15-bit row.
  - Evaluated on load: hit = valid && row match; conflict = valid && row mismatch; both 0 on a miss.
  - On load, the entry is written to valid with the new row, so the next request already sees the update.
- Refresh counter:
  - Decrements every cycle in all states except WAIT_INIT.
  - At 0 it reloads REFI_CYCLES-1 and increments ref_debt, saturating at MAX_REF_DEBT.
- FSM states:
  - WAIT_INIT: nothing issues. Go to RUN when init_done = 1.
  - RUN: normal issue. When ref_debt > 0, stop loading new requests. Go to REF_DRAIN.
  - REF_DRAIN: wait until the output register is empty, i.e. issue_valid = 0, or the held request handshakes. Go to REF_WAIT.
  - REF_WAIT:
    - ref_req = 1 until ref_ack.
    - On ack: ref_debt decrements and all table entries are invalidated (all-bank refresh precharges).
    - If debt is still > 0, go to REF_DRAIN (immediately satisfied). Otherwise go to RUN.
- Corner cases:
  - A counter expiry and ref_ack in the same cycle leave ref_debt unchanged.
  - ref_ack outside REF_WAIT is ignored.
  - Reset mid-operation discards FIFO contents and debt.

Decomposition:
- dram_pkg additions:
  - ADDR_W = RANK_BITS+ROW_BITS+BANK_GROUP_BITS+BANK_BITS+COLUMN_BITS+OFFSET_BITS+IGNORE_BITS (33).
  - dram_addr_t packed struct in the field order above.
  - sched_state_t enum {WAIT_INIT, RUN, REF_DRAIN, REF_WAIT}.
- Sub-module dram_req_fifo: parameterised synchronous FIFO with count, full and empty.

Test Plan:
1. Reset with init_done = 0 and 3 requests pushed → fifo_count = 3, issue_valid = 0. Raise init_done → first request issues one cycle later.
2. Read 0x0_0002_0000 then 0x0_0002_0008 with issue_ready = 1 → row 1, bg 0, bank 0, col 0 then col 1. First has hit = 0, conflict = 0; second has hit = 1.
3. Row 1 then row 2 in the same bank (addr 0x0_0004_0000) → second has conflict = 1, hit = 0. The same row in a different bank gives a miss.
4. 8 pushes with issue_ready = 0 → req_ready = 0 at count 8. The 9th request is not accepted. issue_* stay stable until ready.
5. REFI_CYCLES = 50, steady traffic → ref_req rises after the in-flight issue completes and no issue_valid appears until ref_ack. The next request to a previously open row reports hit = 0.
6. Hold ref_ack low for 3 intervals → ref_debt = 3 and three ref_req/ack rounds occur back-to-back. Assert nRST low mid-run → outputs clear immediately.

Source files
------------

// File: rtl/dram_req_scheduler_pkg.sv
// Shared DRAM request-path types: address layout, scheduler state and the
// request word carried through the front-end FIFO.
package dram_req_scheduler_pkg;

  localparam int RANK_BITS       = 1;
  localparam int ROW_BITS        = 15;
  localparam int BANK_GROUP_BITS = 2;
  localparam int BANK_BITS       = 2;
  localparam int COLUMN_BITS     = 10;
  localparam int OFFSET_BITS     = 2;
  localparam int IGNORE_BITS     = 1;
  localparam int ADDR_W          = RANK_BITS + ROW_BITS + BANK_GROUP_BITS + BANK_BITS +
                                   COLUMN_BITS + OFFSET_BITS + IGNORE_BITS;

  // 7.8 us average refresh interval at a 1.2 GHz controller clock
  localparam int tREFI = 9360;

  typedef logic [63:0] word_t;

  typedef struct packed {
    logic [RANK_BITS-1:0]       rank;
    logic [ROW_BITS-1:0]        row;
    logic [BANK_GROUP_BITS-1:0] bg;
    logic [BANK_BITS-1:0]       bank;
    logic [COLUMN_BITS-1:0]     col;
    logic [OFFSET_BITS-1:0]     offset;
    logic [IGNORE_BITS-1:0]     ignore;
  } dram_addr_t;

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    RUN       = 2'd1,
    REF_DRAIN = 2'd2,
    REF_WAIT  = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic                       wr;
    logic [RANK_BITS-1:0]       rank;
    logic [ROW_BITS-1:0]        row;
    logic [BANK_GROUP_BITS-1:0] bg;
    logic [BANK_BITS-1:0]       bank;
    logic [COLUMN_BITS-1:0]     col;
    word_t                      wdata;
  } sched_req_t;

endpackage

// File: rtl/dram_req_fifo.sv
// Synchronous FIFO with occupancy count; head word is visible combinationally
// on o_rdata whenever the FIFO is not empty.
module dram_req_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // NOTE: storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_wdata;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dram_req_scheduler.sv
// Request front-end for the DRAM command FSM: buffers requests, tags row
// hit/conflict from an open-row table and schedules tREFI refreshes.
module dram_req_scheduler
  import dram_req_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int REFI_CYCLES  = tREFI,
  parameter int MAX_REF_DEBT = 8
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        init_done,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic                        req_wr,
  input  logic [63:0]                 req_wdata,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic                        issue_wr,
  output logic                        issue_rank,
  output logic [1:0]                  issue_bg,
  output logic [1:0]                  issue_bank,
  output logic [14:0]                 issue_row,
  output logic [9:0]                  issue_col,
  output logic [63:0]                 issue_wdata,
  output logic                        issue_hit,
  output logic                        issue_conflict,
  output logic                        ref_req,
  input  logic                        ref_ack,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int CNT_W  = $clog2(REFI_CYCLES);
  localparam int DEBT_W = $clog2(MAX_REF_DEBT + 1);
  localparam int IDX_W  = RANK_BITS + BANK_GROUP_BITS + BANK_BITS;
  localparam int TBL_N  = 1 << IDX_W;

  sched_state_t        r_state, w_state_next;
  logic [CNT_W-1:0]    r_refi_cnt;
  logic [DEBT_W-1:0]   r_ref_debt, w_debt_next;
  logic                r_issue_valid, r_hit, r_conflict;
  sched_req_t          r_issue, w_in_req, w_head;
  logic [TBL_N-1:0]    r_tbl_valid;
  logic [ROW_BITS-1:0] r_tbl_row [TBL_N];
  dram_addr_t          w_in_addr;
  logic [IDX_W-1:0]    w_idx;
  logic                w_full, w_empty, w_push, w_load, w_expire, w_ack;
  logic                w_tbl_valid, w_row_match;
  logic                w_unused_addr;

  assign w_in_addr     = req_addr;
  assign w_unused_addr = ^{w_in_addr.offset, w_in_addr.ignore};
  assign w_in_req      = '{wr: req_wr, rank: w_in_addr.rank, row: w_in_addr.row, bg: w_in_addr.bg,
                           bank: w_in_addr.bank, col: w_in_addr.col, wdata: req_wdata};

  assign req_ready = !w_full;
  assign w_push    = req_valid && !w_full;
  assign w_load    = (r_state == RUN) && (r_ref_debt == '0) && !w_empty &&
                     (!r_issue_valid || issue_ready);

  dram_req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(sched_req_t))) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (nRST),
    .i_push  (w_push),
    .i_wdata (w_in_req),
    .i_pop   (w_load),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  assign w_idx       = {w_head.rank, w_head.bg, w_head.bank};
  assign w_tbl_valid = r_tbl_valid[w_idx];
  assign w_row_match = (r_tbl_row[w_idx] == w_head.row);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_issue_valid <= 1'b0;
      r_issue       <= '0;
      r_hit         <= 1'b0;
      r_conflict    <= 1'b0;
    end else if (w_load) begin
      r_issue_valid <= 1'b1;
      r_issue       <= w_head;
      r_hit         <= w_tbl_valid && w_row_match;
      r_conflict    <= w_tbl_valid && !w_row_match;
    end else if (issue_ready) begin
      r_issue_valid <= 1'b0;
    end
  end

  // An all-bank refresh closes every row, so the whole table drops on ack.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)       r_tbl_valid        <= '0;
    else if (w_ack)  r_tbl_valid        <= '0;
    else if (w_load) r_tbl_valid[w_idx] <= 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (w_load) r_tbl_row[w_idx] <= w_head.row;
  end

  assign w_expire = (r_state != WAIT_INIT) && (r_refi_cnt == '0);
  assign w_ack    = ref_ack && (r_state == REF_WAIT);

  // NOTE: combinational blocks assign defaults first so no path infers a latch.
  always_comb begin
    w_debt_next = r_ref_debt;
    if (w_expire && !w_ack) begin
      if (r_ref_debt != DEBT_W'(MAX_REF_DEBT)) w_debt_next = r_ref_debt + 1'b1;
    end else if (w_ack && !w_expire) begin
      w_debt_next = r_ref_debt - 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      WAIT_INIT: if (init_done) w_state_next = RUN;
      RUN:       if (r_ref_debt != '0) w_state_next = REF_DRAIN;
      REF_DRAIN: if (!r_issue_valid || issue_ready) w_state_next = REF_WAIT;
      REF_WAIT:  if (w_ack) w_state_next = (w_debt_next != '0) ? REF_DRAIN : RUN;
      default:   w_state_next = WAIT_INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= WAIT_INIT;
      r_refi_cnt <= CNT_W'(REFI_CYCLES - 1);
      r_ref_debt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_ref_debt <= w_debt_next;
      if (r_state != WAIT_INIT)
        r_refi_cnt <= w_expire ? CNT_W'(REFI_CYCLES - 1) : r_refi_cnt - 1'b1;
    end
  end

  assign ref_req        = (r_state == REF_WAIT);
  assign issue_valid    = r_issue_valid;
  assign issue_wr       = r_issue.wr;
  assign issue_rank     = r_issue.rank;
  assign issue_bg       = r_issue.bg;
  assign issue_bank     = r_issue.bank;
  assign issue_row      = r_issue.row;
  assign issue_col      = r_issue.col;
  assign issue_wdata    = r_issue.wdata;
  assign issue_hit      = r_hit;
  assign issue_conflict = r_conflict;

endmodule
